picoblaze_cmd_port: RTL and testbench
=====================================

// Module: picoblaze_cmd_port
// PURPOSE
//  Parametrised PicoBlaze (kcpsm6) I/O port block: decodes output-port writes, buffers key
//  commands in a FIFO, emits control pulses, and muxes the CPU input port and interrupt.
//  Sits between kcpsm6 and the datapath/state machine. Adds key buffering, a fixed-length
//  reset pulse, status read-back and a latched start interrupt.
// PARAMETERS
//  PORT_KEY    8'h01  port_id for key-command writes (pushed into FIFO)
//  PORT_STATE  8'h02  port_id for EstadoPort register writes
//  PORT_STATUS 8'h03  port_id for status read-back
//  FIFO_DEPTH  4      key FIFO entries; power of 2, 2..16
//  RESET_CYCLES 1044  resetO high time in clk cycles, >=1
//  INIT_CODE   8'h02  byte presented to CPU while start interrupt pending
//  KEY_UP 8'h57, KEY_DOWN 8'h53, KEY_LEFT 8'h65, KEY_RIGHT 8'h68, KEY_RST 8'h08, KEY_INSTR 8'h73
// PORTS
//  clk            in   1  system clock, all logic on rising edge
//  reset          in   1  asynchronous, active-low reset
//  write_strobe   in   1  kcpsm6 write strobe
//  read_strobe    in   1  kcpsm6 read strobe
//  port_id        in   8  kcpsm6 port address
//  out_port       in   8  kcpsm6 write data
//  in_port_ext    in   8  external data for CPU reads on non-status ports
//  inicio         in   1  start request, level; rising edge raises interrupt
//  irq_ext        in   1  external interrupt request, passed through
//  interrupt_ack  in   1  kcpsm6 interrupt acknowledge
//  cpu_in_port    out  8  to kcpsm6 in_port (combinational mux)
//  cpu_interrupt  out  1  to kcpsm6 interrupt
//  EstadoPort     out  8  state register for main FSM
//  instrucciones  out  1  instruction-display toggle
//  resetO         out  1  system reset pulse, RESET_CYCLES long
//  sumar/restar   out  1  one-cycle increment/decrement pulses
//  izquierda/derecha out 1 one-cycle register-select pulses
// BEHAVIOUR
//  Reset: all registers, outputs, FIFO pointers, flags and counters = 0; FIFO empty.
//  Port writes (write_strobe=1): port_id==PORT_STATE -> EstadoPort<=out_port next edge; holds otherwise.
//   port_id==PORT_KEY -> push out_port if not full; if full, drop and set overflow (sticky).
//   Other port_ids ignored.
//  Pop: one entry per cycle whenever FIFO non-empty; push+pop same cycle legal (count unchanged;
//   push at full with simultaneous pop accepted, no overflow).
//  Latency: write at edge N -> pop at N+1 -> decoded pulse registered high for cycle N+2 only.
//  Decode of popped byte: KEY_UP->sumar, KEY_DOWN->restar, KEY_LEFT->izquierda,
//   KEY_RIGHT->derecha (1 cycle each); KEY_INSTR toggles instrucciones once;
//   KEY_RST starts reset pulse; any other code discarded silently.
//  Reset-pulse FSM: IDLE -> (KEY_RST popped) -> BUSY: resetO=1, counter 0..RESET_CYCLES-1,
//   then IDLE with resetO=0. KEY_RST popped while BUSY ignored (no restart, no cancel).
//   FIFO keeps draining during BUSY.
//  Start interrupt: rising edge of inicio (registered prev value) sets int_pending;
//   interrupt_ack clears it; simultaneous edge and ack -> stays set.
//   cpu_interrupt = int_pending | irq_ext.
//  cpu_in_port: INIT_CODE if int_pending; else status byte if port_id==PORT_STATUS; else in_port_ext.
//  Status byte: {overflow, full, empty, resetO, instrucciones, count[2:0] saturated at 7}.
//   read_strobe with port_id==PORT_STATUS clears overflow next edge; new overflow same cycle wins.
//  Async reset asserted mid-pulse or mid-drain: immediate return to reset values.
// TESTING
//  Write 8'h57 to port 01 at edge N -> sumar high exactly cycle N+2; restar/izq/der stay 0.
//  Five back-to-back writes 57,53,65,68,73 (depth 4, drain active) -> five pulses on
//   consecutive cycles, instrucciones toggles to 1, no overflow.
//  Hold FIFO full via 6 writes in one burst with drain -> status bit7 not set; force full
//   (FIFO_DEPTH=2, writes 3 per cycle impossible -> stall via param test) -> overflow=1, read
//   port 03 -> overflow 0.
//  Write 8'h08 -> resetO high exactly 1044 cycles; second 8'h08 at cycle 500 -> no extension.
//  inicio 0->1 -> cpu_interrupt=1, cpu_in_port=8'h02; interrupt_ack -> both revert.
//  Write 8'hA5 to port 02 -> EstadoPort=A5 next edge; reset low mid-pulse -> all outputs 0.

Source files
------------

// File: rtl/picoblaze_cmd_port.sv
// PicoBlaze (kcpsm6) I/O port block.
// Decodes output-port writes, buffers key commands in a FIFO that drains one entry per cycle,
// turns each popped key into a control pulse, generates a fixed-length reset pulse, and muxes
// the CPU input port (start code / status byte / external data) and interrupt line.
// Ports:
//   clk, reset (async, active-low)
//   write_strobe, read_strobe, port_id, out_port  - kcpsm6 bus
//   in_port_ext, inicio, irq_ext, interrupt_ack   - external data, start request, irq, ack
//   cpu_in_port, cpu_interrupt                    - back to kcpsm6
//   EstadoPort, instrucciones, resetO             - state register, display toggle, reset pulse
//   sumar, restar, izquierda, derecha             - one-cycle command pulses
module picoblaze_cmd_port #(
   parameter logic [7:0]  PORT_KEY     = 8'h01,
   parameter logic [7:0]  PORT_STATE   = 8'h02,
   parameter logic [7:0]  PORT_STATUS  = 8'h03,
   parameter int unsigned FIFO_DEPTH   = 4,
   parameter int unsigned RESET_CYCLES = 1044,
   parameter logic [7:0]  INIT_CODE    = 8'h02,
   parameter logic [7:0]  KEY_UP       = 8'h57,
   parameter logic [7:0]  KEY_DOWN     = 8'h53,
   parameter logic [7:0]  KEY_LEFT     = 8'h65,
   parameter logic [7:0]  KEY_RIGHT    = 8'h68,
   parameter logic [7:0]  KEY_RST      = 8'h08,
   parameter logic [7:0]  KEY_INSTR    = 8'h73
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       write_strobe,
   input  logic       read_strobe,
   input  logic [7:0] port_id,
   input  logic [7:0] out_port,
   input  logic [7:0] in_port_ext,
   input  logic       inicio,
   input  logic       irq_ext,
   input  logic       interrupt_ack,
   output logic [7:0] cpu_in_port,
   output logic       cpu_interrupt,
   output logic [7:0] EstadoPort,
   output logic       instrucciones,
   output logic       resetO,
   output logic       sumar,
   output logic       restar,
   output logic       izquierda,
   output logic       derecha
);

   localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
   localparam int unsigned CntW = PtrW + 1;
   localparam int unsigned RcW  = $clog2(RESET_CYCLES + 1);

   typedef enum logic [0:0] {StIdle, StBusy} rst_state_e;

   logic [7:0]      mem_q [FIFO_DEPTH];
   logic [7:0]      mem_d [FIFO_DEPTH];
   logic [PtrW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CntW-1:0] count_q, count_d;
   logic            ovf_q, ovf_d;
   logic            pop_valid_q, pop_valid_d;
   logic [7:0]      pop_byte_q, pop_byte_d;
   logic            sumar_q, sumar_d, restar_q, restar_d;
   logic            izq_q, izq_d, der_q, der_d;
   logic            instr_q, instr_d;
   logic [7:0]      estado_q, estado_d;
   logic            inicio_q, inicio_d;
   logic            pend_q, pend_d;
   rst_state_e      state_q, state_d;
   logic [RcW-1:0]  rcnt_q, rcnt_d;

   logic       key_wr, pop, push, full, empty, rst_req;
   logic [2:0] cnt_sat;
   logic [7:0] status;

   assign key_wr  = write_strobe && (port_id == PORT_KEY);
   assign full    = (count_q == CntW'(FIFO_DEPTH));
   assign empty   = (count_q == '0);
   assign pop     = !empty;
   // A simultaneous pop frees a slot, so a write at full is still accepted.
   assign push    = key_wr && (!full || pop);
   assign rst_req = pop_valid_q && (pop_byte_q == KEY_RST);

   // FIFO, decode and register next-state
   always_comb begin
      mem_d       = mem_q;
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      count_d     = count_q;
      pop_byte_d  = pop_byte_q;
      pop_valid_d = pop;
      if (push) begin
         mem_d[wr_ptr_q] = out_port;
         wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (pop) begin
         pop_byte_d = mem_q[rd_ptr_q];
         rd_ptr_d   = rd_ptr_q + 1'b1;
      end
      unique case ({push, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase

      // Overflow set beats a same-cycle status-read clear.
      if (key_wr && !push)                                 ovf_d = 1'b1;
      else if (read_strobe && (port_id == PORT_STATUS))    ovf_d = 1'b0;
      else                                                 ovf_d = ovf_q;

      sumar_d  = pop_valid_q && (pop_byte_q == KEY_UP);
      restar_d = pop_valid_q && (pop_byte_q == KEY_DOWN);
      izq_d    = pop_valid_q && (pop_byte_q == KEY_LEFT);
      der_d    = pop_valid_q && (pop_byte_q == KEY_RIGHT);
      instr_d  = instr_q ^ (pop_valid_q && (pop_byte_q == KEY_INSTR));

      estado_d = (write_strobe && (port_id == PORT_STATE)) ? out_port : estado_q;

      inicio_d = inicio;
      if (inicio && !inicio_q)  pend_d = 1'b1;
      else if (interrupt_ack)   pend_d = 1'b0;
      else                      pend_d = pend_q;
   end

   // Reset-pulse FSM: state register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= StIdle;
         rcnt_q  <= '0;
      end else begin
         state_q <= state_d;
         rcnt_q  <= rcnt_d;
      end
   end

   // Reset-pulse FSM: next state; KEY_RST while busy is ignored
   always_comb begin
      state_d = state_q;
      rcnt_d  = '0;
      unique case (state_q)
         StIdle: if (rst_req) state_d = StBusy;
         StBusy: begin
            if (rcnt_q == RcW'(RESET_CYCLES - 1)) state_d = StIdle;
            else                                  rcnt_d  = rcnt_q + 1'b1;
         end
         default: state_d = StIdle;
      endcase
   end

   // Reset-pulse FSM: outputs
   always_comb begin
      resetO = (state_q == StBusy);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         ovf_q       <= 1'b0;
         pop_valid_q <= 1'b0;
         pop_byte_q  <= '0;
         sumar_q     <= 1'b0;
         restar_q    <= 1'b0;
         izq_q       <= 1'b0;
         der_q       <= 1'b0;
         instr_q     <= 1'b0;
         estado_q    <= '0;
         inicio_q    <= 1'b0;
         pend_q      <= 1'b0;
      end else begin
         mem_q       <= mem_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         ovf_q       <= ovf_d;
         pop_valid_q <= pop_valid_d;
         pop_byte_q  <= pop_byte_d;
         sumar_q     <= sumar_d;
         restar_q    <= restar_d;
         izq_q       <= izq_d;
         der_q       <= der_d;
         instr_q     <= instr_d;
         estado_q    <= estado_d;
         inicio_q    <= inicio_d;
         pend_q      <= pend_d;
      end
   end

   always_comb begin
      cnt_sat = (int'(count_q) > 7) ? 3'd7 : 3'(count_q);
      status  = {ovf_q, full, empty, resetO, instr_q, cnt_sat};
      if (pend_q)                        cpu_in_port = INIT_CODE;
      else if (port_id == PORT_STATUS)   cpu_in_port = status;
      else                               cpu_in_port = in_port_ext;
   end

   assign cpu_interrupt = pend_q | irq_ext;
   assign EstadoPort    = estado_q;
   assign instrucciones = instr_q;
   assign sumar         = sumar_q;
   assign restar        = restar_q;
   assign izquierda     = izq_q;
   assign derecha       = der_q;

endmodule

// File: tb/tb_picoblaze_cmd_port.sv
// Randomized self-checking bench for picoblaze_cmd_port with a queue-based reference model
// and directed literal checks of latency, burst, reset-pulse length and interrupt behaviour.
module tb_picoblaze_cmd_port;

   localparam int DEPTH = 4;
   localparam int RCYC  = 1044;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       ws = 1'b0, rs = 1'b0, inicio = 1'b0, irq = 1'b0, ack = 1'b0;
   logic [7:0] pid = 8'h00, op = 8'h00, ext = 8'h00;
   logic [7:0] cpu_in_port, estado;
   logic       cpu_int, instr, reset_o, sumar, restar, izq, der;

   int total = 0;
   int bad   = 0;
   bit chk_en = 1'b0;

   picoblaze_cmd_port dut (
      .clk(clk), .reset(rst_n), .write_strobe(ws), .read_strobe(rs), .port_id(pid),
      .out_port(op), .in_port_ext(ext), .inicio(inicio), .irq_ext(irq),
      .interrupt_ack(ack), .cpu_in_port(cpu_in_port), .cpu_interrupt(cpu_int),
      .EstadoPort(estado), .instrucciones(instr), .resetO(reset_o), .sumar(sumar),
      .restar(restar), .izquierda(izq), .derecha(der)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   logic [7:0] mq[$];
   bit         m_pv;
   logic [7:0] m_pb;
   int         m_rst_left;
   bit         m_instr, m_su, m_re, m_iz, m_de, m_ovf, m_pend, m_prev_inicio;
   logic [7:0] m_estado;

   task automatic m_reset();
      mq.delete();
      m_pv = 0; m_pb = 0; m_rst_left = 0; m_instr = 0;
      m_su = 0; m_re = 0; m_iz = 0; m_de = 0; m_ovf = 0; m_pend = 0;
      m_prev_inicio = 0; m_estado = 0;
   endtask

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) m_reset();
      else begin
         bit pop_now, was_full, ovf_set;
         logic [7:0] head;
         pop_now  = (mq.size() > 0);
         was_full = (mq.size() == DEPTH);
         head     = pop_now ? mq[0] : 8'h00;
         ovf_set  = 0;
         // effects of the byte popped on the previous edge
         m_su = m_pv && (m_pb == 8'h57);
         m_re = m_pv && (m_pb == 8'h53);
         m_iz = m_pv && (m_pb == 8'h65);
         m_de = m_pv && (m_pb == 8'h68);
         if (m_pv && m_pb == 8'h73) m_instr = ~m_instr;
         if (m_rst_left > 0) m_rst_left--;
         else if (m_pv && m_pb == 8'h08) m_rst_left = RCYC;
         m_pv = pop_now;
         m_pb = head;
         if (pop_now) void'(mq.pop_front());
         if (ws && pid == 8'h01) begin
            if (!was_full || pop_now) mq.push_back(op);
            else ovf_set = 1;
         end
         if (ovf_set) m_ovf = 1;
         else if (rs && pid == 8'h03) m_ovf = 0;
         if (ws && pid == 8'h02) m_estado = op;
         if (inicio && !m_prev_inicio) m_pend = 1;
         else if (ack) m_pend = 0;
         m_prev_inicio = inicio;
      end
   end

   function automatic logic [7:0] m_cpu_in();
      logic [2:0] sat;
      logic [7:0] st;
      sat = (mq.size() > 7) ? 3'd7 : 3'(mq.size());
      st  = {m_ovf, mq.size() == DEPTH, mq.size() == 0, m_rst_left > 0, m_instr, sat};
      if (m_pend) return 8'h02;
      if (pid == 8'h03) return st;
      return ext;
   endfunction

   // ---------------- compare process ----------------
   always @(negedge clk) begin
      if (chk_en) begin
         chk("cpu_in_port", {24'd0, cpu_in_port}, {24'd0, m_cpu_in()});
         chk("cpu_interrupt", {31'd0, cpu_int}, {31'd0, m_pend | irq});
         chk("EstadoPort", {24'd0, estado}, {24'd0, m_estado});
         chk("instrucciones", {31'd0, instr}, {31'd0, m_instr});
         chk("resetO", {31'd0, reset_o}, {31'd0, m_rst_left > 0});
         chk("pulses", {28'd0, sumar, restar, izq, der}, {28'd0, m_su, m_re, m_iz, m_de});
      end
   end

   // ---------------- stimulus ----------------
   task automatic idle();
      ws = 0; rs = 0; ack = 0; pid = 8'h00;
   endtask

   task automatic cyc(input int n);
      for (int i = 0; i < n; i++) @(negedge clk);
      #1;
   endtask

   initial begin
      logic [7:0] keys [5];
      logic [3:0] pv [4];
      logic [7:0] klist [7];
      int cnt, n;
      keys = '{8'h57, 8'h53, 8'h65, 8'h68, 8'h73};
      pv   = '{4'b1000, 4'b0100, 4'b0010, 4'b0001};
      klist = '{8'h57, 8'h53, 8'h65, 8'h68, 8'h73, 8'h08, 8'h11};

      chk_en = 1;
      cyc(3);
      rst_n = 1;
      ext = 8'h3C;
      pid = 8'h03;
      @(negedge clk);
      chk("reset_status", {24'd0, cpu_in_port}, 32'h20);
      chk("reset_estado", {24'd0, estado}, 32'h0);
      #1 idle();
      cyc(2);

      // single key: write at edge N, pulse visible only after edge N+2
      ws = 1; pid = 8'h01; op = 8'h57;
      @(negedge clk); #1 idle();
      @(negedge clk); chk("up_n1", {31'd0, sumar}, 32'd0);
      @(negedge clk); chk("up_n2", {28'd0, sumar, restar, izq, der}, 32'h8);
      @(negedge clk); chk("up_n3", {31'd0, sumar}, 32'd0);
      #1 cyc(2);

      // five back-to-back keys
      for (int i = 0; i < 8; i++) begin
         if (i < 5) begin ws = 1; pid = 8'h01; op = keys[i]; end
         else idle();
         @(negedge clk);
         if (i >= 2 && i <= 5)
            chk("burst_pulse", {28'd0, sumar, restar, izq, der}, {28'd0, pv[i-2]});
         if (i == 6) begin
            chk("burst_idle", {28'd0, sumar, restar, izq, der}, 32'd0);
            chk("burst_instr", {31'd0, instr}, 32'd1);
         end
         #1;
      end
      pid = 8'h03; rs = 1;
      @(negedge clk);
      chk("burst_status", {24'd0, cpu_in_port}, 32'h28);
      #1 idle();

      // state register
      ws = 1; pid = 8'h02; op = 8'hA5;
      @(negedge clk);
      chk("estado_a5", {24'd0, estado}, 32'hA5);
      #1 idle();

      // start interrupt
      inicio = 1;
      @(negedge clk);
      chk("int_set", {31'd0, cpu_int}, 32'd1);
      chk("int_code", {24'd0, cpu_in_port}, 32'h02);
      #1 ack = 1;
      @(negedge clk);
      chk("int_clr", {31'd0, cpu_int}, 32'd0);
      chk("int_ext", {24'd0, cpu_in_port}, 32'h3C);
      #1 ack = 0; inicio = 0;
      cyc(2);

      // reset pulse length with a second KEY_RST part-way through
      ws = 1; pid = 8'h01; op = 8'h08;
      @(negedge clk); #1 idle();
      n = 0;
      while (reset_o !== 1'b1 && n < 10) begin @(negedge clk); n++; end
      chk("rst_rise", {31'd0, reset_o}, 32'd1);
      cnt = 0;
      while (reset_o === 1'b1 && cnt < 2000) begin
         cnt++;
         #1;
         if (cnt == 500) begin ws = 1; pid = 8'h01; op = 8'h08; end
         else idle();
         @(negedge clk);
      end
      chk("rst_len", cnt, RCYC);
      #1 idle();
      cyc(3);

      // async reset mid-pulse
      ws = 1; pid = 8'h01; op = 8'h08;
      @(negedge clk); #1 idle();
      cyc(20);
      rst_n = 0;
      #1;
      chk("ar_reseto", {31'd0, reset_o}, 32'd0);
      chk("ar_estado", {24'd0, estado}, 32'd0);
      chk("ar_instr", {31'd0, instr}, 32'd0);
      @(negedge clk); #1 rst_n = 1;
      cyc(2);

      // randomized traffic
      for (int c = 0; c < 3000; c++) begin
         ws  = ($urandom_range(0, 1) == 1);
         rs  = ($urandom_range(0, 3) == 0);
         ack = ($urandom_range(0, 3) == 0);
         irq = ($urandom_range(0, 7) == 0);
         if ($urandom_range(0, 15) == 0) inicio = ~inicio;
         n = $urandom_range(0, 7);
         pid = (n < 4) ? 8'h01 : (n == 4) ? 8'h02 : (n == 5) ? 8'h03 : 8'($urandom);
         if ($urandom_range(0, 3) == 0) op = 8'($urandom);
         else begin
            n = $urandom_range(0, 6);
            if (n == 5 && $urandom_range(0, 7) != 0) n = 0;
            op = klist[n];
         end
         ext = 8'($urandom);
         if (c == 1500) rst_n = 0;
         if (c == 1502) rst_n = 1;
         @(negedge clk); #1;
      end
      idle();
      cyc(2);
      chk_en = 0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
